// File: rtl/anode_scanner.sv
// Four-digit seven-segment refresh scanner with per-slot duty-cycle dimming and blanking.
// Every output is a flop; anode is computed from the pre-edge scan state.
module anode_scanner #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       blank,
    input  logic [2:0] brightness,
    output logic [3:0] anode,
    output logic [1:0] digit_sel,
    output logic       tick
);

    localparam int unsigned SLOT = REFRESH_DIV / 8;
    localparam int unsigned CW   = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    if (REFRESH_DIV < 8 || (REFRESH_DIV % 8) != 0) begin : g_bad_refresh_div
        $error("REFRESH_DIV must be >= 8 and a multiple of 8");
    end

    logic [CW-1:0] cnt_q;
    logic [1:0]    digit_q;
    logic [2:0]    bright_q;
    logic [CW:0]   thresh;
    logic          lit;

    // One bit wider than cnt so that bright_q == 7 yields exactly REFRESH_DIV.
    assign thresh = ((CW+1)'(bright_q) + (CW+1)'(1)) * (CW+1)'(SLOT);
    assign lit    = {1'b0, cnt_q} < thresh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            digit_q  <= 2'd0;
            bright_q <= 3'd7;
            anode    <= 4'b1111;
            tick     <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (en) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_q    <= '0;
                    digit_q  <= digit_q + 2'd1;
                    bright_q <= brightness;
                    tick     <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
            if (!blank && lit) begin
                anode <= ~(4'b0001 << digit_q);
            end else begin
                anode <= 4'b1111;
            end
        end
    end

    assign digit_sel = digit_q;

endmodule

// File: tb/tb_anode_scanner.sv
// Scoreboard bench for anode_scanner at REFRESH_DIV=16: a cycle model queues expected outputs
// per edge, and each scenario task pops and compares them alongside scenario-specific checks.
module tb_anode_scanner;

    localparam int unsigned RD = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       blank;
    logic [2:0] brightness;
    logic [3:0] anode;
    logic [1:0] digit_sel;
    logic       tick;

    int n_checks = 0;
    int n_err    = 0;

    int   m_cnt;
    int   m_digit;
    int   m_bright;
    logic m_tick;

    logic [6:0] sb_q[$];
    logic [6:0] exp_v;

    always #5 clk = ~clk;

    anode_scanner #(.REFRESH_DIV(RD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .blank(blank),
        .brightness(brightness),
        .anode(anode),
        .digit_sel(digit_sel),
        .tick(tick)
    );

    function automatic logic [3:0] digit_anode(input int d);
        case (d)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt    = 0;
        m_digit  = 0;
        m_bright = 7;
        m_tick   = 1'b0;
    endtask

    // Drive one cycle of inputs, queue what the outputs must be after the edge, land on negedge.
    task automatic drive(input logic e, input logic b, input logic [2:0] br);
        logic [3:0] a;
        en         = e;
        blank      = b;
        brightness = br;
        a = (!b && (m_cnt * 8 < (m_bright + 1) * int'(RD))) ? digit_anode(m_digit) : 4'b1111;
        m_tick = 1'b0;
        if (e) begin
            if (m_cnt == int'(RD) - 1) begin
                m_cnt    = 0;
                m_digit  = (m_digit + 1) % 4;
                m_bright = int'(br);
                m_tick   = 1'b1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        sb_q.push_back({a, 2'(m_digit), m_tick});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        en         = 1'b0;
        blank      = 1'b0;
        brightness = 3'd7;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({anode, digit_sel, tick} !== 7'b1111_00_0) begin
            n_err++;
            $display("FAIL reset: got anode=%b sel=%0d tick=%b want anode=1111 sel=0 tick=0",
                     anode, digit_sel, tick);
        end
        en    = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        logic [3:0] ea;
        for (int k = 1; k <= 80; k++) begin
            drive(1'b1, 1'b0, 3'd7);
            exp_v = sb_q.pop_front();
            n_checks++;
            if ({anode, digit_sel, tick} !== exp_v) begin
                n_err++;
                $display("FAIL scan_sb: got anode=%b sel=%0d tick=%b want anode=%b sel=%0d tick=%b",
                         anode, digit_sel, tick, exp_v[6:3], exp_v[2:1], exp_v[0]);
            end
            ea = digit_anode(((k - 1) / 16) % 4);
            n_checks++;
            if (anode !== ea || digit_sel !== 2'((k / 16) % 4) || tick !== (k % 16 == 0)) begin
                n_err++;
                $display("FAIL scan_order k=%0d: got anode=%b sel=%0d tick=%b want anode=%b sel=%0d tick=%b",
                         k, anode, digit_sel, tick, ea, (k / 16) % 4, (k % 16 == 0));
            end
        end
    endtask

    task automatic test_dimming();
        int lit_cnt;
        int want[4] = '{16, 2, 8, 16};
        logic [2:0] br;
        for (int s = 0; s < 4; s++) begin
            lit_cnt = 0;
            for (int i = 0; i < 16; i++) begin
                case (s)
                    0:       br = 3'd0;
                    1:       br = 3'd3;
                    2:       br = (i < 4) ? 3'd3 : 3'd7;
                    default: br = 3'd7;
                endcase
                drive(1'b1, 1'b0, br);
                exp_v = sb_q.pop_front();
                n_checks++;
                if ({anode, digit_sel, tick} !== exp_v) begin
                    n_err++;
                    $display("FAIL dim_sb: got anode=%b sel=%0d tick=%b want anode=%b sel=%0d tick=%b",
                             anode, digit_sel, tick, exp_v[6:3], exp_v[2:1], exp_v[0]);
                end
                if (anode !== 4'b1111) lit_cnt++;
            end
            n_checks++;
            if (lit_cnt != want[s]) begin
                n_err++;
                $display("FAIL dim_lit slot=%0d: got %0d lit cycles want %0d", s, lit_cnt, want[s]);
            end
        end
    endtask

    task automatic test_blank();
        logic [3:0] ea;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, (i >= 4 && i < 9), 3'd7);
            exp_v = sb_q.pop_front();
            n_checks++;
            if ({anode, digit_sel, tick} !== exp_v) begin
                n_err++;
                $display("FAIL blank_sb: got anode=%b sel=%0d tick=%b want anode=%b sel=%0d tick=%b",
                         anode, digit_sel, tick, exp_v[6:3], exp_v[2:1], exp_v[0]);
            end
            ea = (i >= 4 && i <= 8) ? 4'b1111 : 4'b1101;
            n_checks++;
            if (anode !== ea || tick !== (i == 15) || digit_sel !== ((i == 15) ? 2'd2 : 2'd1)) begin
                n_err++;
                $display("FAIL blank_window i=%0d: got anode=%b sel=%0d tick=%b want anode=%b",
                         i, anode, digit_sel, tick, ea);
            end
        end
    endtask

    task automatic test_enable_hold();
        logic       e;
        logic [1:0] es;
        logic       et;
        logic [3:0] ea;
        logic       chk;
        for (int i = 0; i < 55; i++) begin
            // 10 run, 20 hold at cnt=10, 6 run to wrap, 15 run, 3 hold at wrap, 1 run
            e   = !((i >= 10 && i < 30) || (i >= 51 && i < 54));
            chk = 1'b1;
            ea  = 4'b1011;
            es  = 2'd2;
            et  = 1'b0;
            if (i < 10) chk = 1'b0;
            else if (i >= 30 && i < 36) begin
                et = (i == 35);
                es = (i == 35) ? 2'd3 : 2'd2;
            end else if (i >= 36 && i < 51) chk = 1'b0;
            else if (i >= 51) begin
                ea = 4'b0111;
                et = (i == 54);
                es = (i == 54) ? 2'd0 : 2'd3;
            end
            drive(e, 1'b0, 3'd7);
            exp_v = sb_q.pop_front();
            n_checks++;
            if ({anode, digit_sel, tick} !== exp_v) begin
                n_err++;
                $display("FAIL en_sb: got anode=%b sel=%0d tick=%b want anode=%b sel=%0d tick=%b",
                         anode, digit_sel, tick, exp_v[6:3], exp_v[2:1], exp_v[0]);
            end
            if (chk) begin
                n_checks++;
                if (anode !== ea || digit_sel !== es || tick !== et) begin
                    n_err++;
                    $display("FAIL en_hold i=%0d: got anode=%b sel=%0d tick=%b want anode=%b sel=%0d tick=%b",
                             i, anode, digit_sel, tick, ea, es, et);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 53; i++) begin
            drive(1'b1, 1'b0, 3'd7);
            exp_v = sb_q.pop_front();
            n_checks++;
            if ({anode, digit_sel, tick} !== exp_v) begin
                n_err++;
                $display("FAIL arst_sb: got anode=%b sel=%0d tick=%b want anode=%b sel=%0d tick=%b",
                         anode, digit_sel, tick, exp_v[6:3], exp_v[2:1], exp_v[0]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({anode, digit_sel, tick} !== 7'b1111_00_0) begin
            n_err++;
            $display("FAIL arst_immediate: got anode=%b sel=%0d tick=%b want anode=1111 sel=0 tick=0",
                     anode, digit_sel, tick);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 3'd7);
            exp_v = sb_q.pop_front();
            n_checks++;
            if ({anode, digit_sel, tick} !== exp_v || anode !== 4'b1110 || tick !== 1'b0) begin
                n_err++;
                $display("FAIL arst_restart i=%0d: got anode=%b sel=%0d tick=%b want anode=1110 sel=0 tick=0",
                         i, anode, digit_sel, tick);
            end
        end
    endtask

    task automatic test_random();
        logic prev_tick = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom_range(3, 0) != 0), ($urandom_range(7, 0) == 0), 3'($urandom_range(7, 0)));
            exp_v = sb_q.pop_front();
            n_checks++;
            if ({anode, digit_sel, tick} !== exp_v) begin
                n_err++;
                $display("FAIL rand_sb i=%0d: got anode=%b sel=%0d tick=%b want anode=%b sel=%0d tick=%b",
                         i, anode, digit_sel, tick, exp_v[6:3], exp_v[2:1], exp_v[0]);
            end
            n_checks++;
            if (!(anode === 4'b1111 || $countones(~anode) == 1)) begin
                n_err++;
                $display("FAIL rand_onehot i=%0d: got anode=%b want one-hot-low or 1111", i, anode);
            end
            n_checks++;
            if (prev_tick === 1'b1 && tick === 1'b1) begin
                n_err++;
                $display("FAIL rand_tick i=%0d: got tick high twice want single-cycle pulse", i);
            end
            prev_tick = tick;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_dimming();
        test_blank();
        test_enable_hold();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
